// File: rtl/resp_signature_compactor.sv
// Folds each accepted 240-bit response sample into a 32-bit MISR and compares it against a golden word on finish.
// Latency: a sample is visible on sig_out one clk after it is accepted; match is registered on the finish edge.
// Backpressure: none. Every y_valid cycle in RUN is absorbed, so the upstream DUT is never stalled.
module resp_signature_compactor #(
    parameter int          Y_W   = 240,
    parameter int          SIG_W = 32,
    parameter logic [31:0] POLY  = 32'h04C11DB7,
    parameter logic [31:0] SEED  = 32'hFFFFFFFF,
    parameter int          CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             y_valid,
    input  logic [Y_W-1:0]   y,
    input  logic             finish,
    input  logic [SIG_W-1:0] golden,
    output logic [SIG_W-1:0] sig_out,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             cnt_ovf,
    output logic             busy,
    output logic             done,
    output logic             match
);

    localparam int NCHUNK = (Y_W + SIG_W - 1) / SIG_W;
    localparam int PAD_W  = NCHUNK * SIG_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [PAD_W-1:0] padded;
    logic [SIG_W-1:0] fold;
    logic [SIG_W-1:0] next_sig;
    logic [SIG_W-1:0] sig_final;

    // Zero-pad y up to a whole number of signature words and XOR the words together.
    always_comb begin
        padded = '0;
        padded[Y_W-1:0] = y;
        fold = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            fold = fold ^ padded[k*SIG_W +: SIG_W];
        end
    end

    assign next_sig  = {sig_out[SIG_W-2:0], 1'b0}
                     ^ (sig_out[SIG_W-1] ? POLY[SIG_W-1:0] : '0)
                     ^ fold;
    // The compare must see a sample accepted on the very finish cycle.
    assign sig_final = y_valid ? next_sig : sig_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sig_out    <= '0;
            sample_cnt <= '0;
            cnt_ovf    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            match      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        sig_out    <= SEED[SIG_W-1:0];
                        sample_cnt <= '0;
                        cnt_ovf    <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        match      <= 1'b0;
                    end
                end
                RUN: begin
                    if (start) begin
                        sig_out    <= SEED[SIG_W-1:0];
                        sample_cnt <= '0;
                        cnt_ovf    <= 1'b0;
                    end else begin
                        if (y_valid) begin
                            sig_out <= next_sig;
                            if (&sample_cnt) begin
                                cnt_ovf <= 1'b1;
                            end else begin
                                sample_cnt <= sample_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                        end
                        if (finish) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            match <= (sig_final == golden);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_resp_signature_compactor.sv
// Directed bench for resp_signature_compactor.
// Expected signatures come from constants or from a bit-serial reference fold.
module tb_resp_signature_compactor;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         y_valid;
    logic [239:0] y;
    logic         finish;
    logic [31:0]  golden;
    logic [31:0]  sig_out;
    logic [7:0]   sample_cnt;
    logic         cnt_ovf;
    logic         busy;
    logic         done;
    logic         match;

    int tests = 0;
    int fails = 0;

    resp_signature_compactor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .y_valid    (y_valid),
        .y          (y),
        .finish     (finish),
        .golden     (golden),
        .sig_out    (sig_out),
        .sample_cnt (sample_cnt),
        .cnt_ovf    (cnt_ovf),
        .busy       (busy),
        .done       (done),
        .match      (match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: bit i of y lands in signature bit i mod 32.
    function automatic logic [31:0] model_step(input logic [31:0] s, input logic [239:0] v);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < 240; i++) f[i % 32] = f[i % 32] ^ v[i];
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^ f;
    endfunction

    function automatic logic [239:0] vec(input int i);
        logic [255:0] w;
        for (int k = 0; k < 8; k++)
            w[k*32 +: 32] = (i + 1) * 32'h9E3779B9 + k * 32'h01010101;
        return w[239:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; y_valid = 1'b0; finish = 1'b0; y = '0; golden = '0;
    endtask

    logic [31:0] m;
    logic [31:0] prev;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #12;
        chk("rst_sig", sig_out, 32'h0);
        chk("rst_cnt", {24'h0, sample_cnt}, 32'h0);
        chk("rst_flags", {28'h0, cnt_ovf, busy, done, match}, 32'h0);
        rst_n = 1'b1;
        tick();

        // IDLE ignores samples and finish
        y_valid = 1'b1; y = vec(3); finish = 1'b1; tick(); idle_inputs();
        chk("idle_ignore_sig", sig_out, 32'h0);
        chk("idle_ignore_flags", {28'h0, cnt_ovf, busy, done, match}, 32'h0);

        // single zero sample, then finish on a separate cycle
        start = 1'b1; tick(); idle_inputs();
        chk("start_sig", sig_out, 32'hFFFFFFFF);
        chk("start_busy", {31'h0, busy}, 32'h1);
        y_valid = 1'b1; y = '0; tick(); idle_inputs();
        chk("zero_sig", sig_out, 32'hFB3EE249);
        finish = 1'b1; golden = 32'hFB3EE249; tick(); idle_inputs();
        chk("zero_cnt", {24'h0, sample_cnt}, 32'h1);
        chk("zero_done_match", {29'h0, busy, done, match}, 32'h3);

        // DONE freezes outputs
        y_valid = 1'b1; y = vec(7); finish = 1'b1; golden = 32'h0; tick(); idle_inputs();
        chk("done_freeze_sig", sig_out, 32'hFB3EE249);
        chk("done_freeze_flags", {24'h0, sample_cnt}, 32'h1);
        chk("done_freeze_match", {31'h0, match}, 32'h1);

        // fold aliasing: y[0] and y[32] give the same signature
        start = 1'b1; tick(); idle_inputs();
        chk("restart_from_done", {30'h0, done, match}, 32'h0);
        y_valid = 1'b1; y = '0; y[0] = 1'b1; finish = 1'b1; golden = 32'hFB3EE249; tick(); idle_inputs();
        chk("alias0_sig", sig_out, 32'hFB3EE248);
        chk("alias0_match", {30'h0, done, match}, 32'h2);
        start = 1'b1; tick(); idle_inputs();
        y_valid = 1'b1; y = '0; y[32] = 1'b1; finish = 1'b1; golden = 32'hFB3EE249; tick(); idle_inputs();
        chk("alias32_sig", sig_out, 32'hFB3EE248);
        chk("alias32_match", {30'h0, done, match}, 32'h2);

        // 22 back-to-back samples, finish with the last one
        start = 1'b1; tick(); idle_inputs();
        m = 32'hFFFFFFFF;
        for (int i = 0; i < 22; i++) m = model_step(m, vec(i));
        for (int i = 0; i < 22; i++) begin
            y_valid = 1'b1; y = vec(i);
            if (i == 21) begin finish = 1'b1; golden = m; end
            tick();
        end
        idle_inputs();
        chk("b2b_cnt", {24'h0, sample_cnt}, 32'd22);
        chk("b2b_sig", sig_out, m);
        chk("b2b_match", {30'h0, done, match}, 32'h3);

        // reset mid-RUN after 5 samples is immediate
        start = 1'b1; tick(); idle_inputs();
        for (int i = 0; i < 5; i++) begin y_valid = 1'b1; y = vec(i + 40); tick(); end
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sig", sig_out, 32'h0);
        chk("arst_cnt", {24'h0, sample_cnt}, 32'h0);
        chk("arst_flags", {28'h0, cnt_ovf, busy, done, match}, 32'h0);
        #3 rst_n = 1'b1;
        y_valid = 1'b1; y = vec(1); finish = 1'b1; tick(); idle_inputs();
        chk("arst_idle", {sig_out[27:0], cnt_ovf, busy, done, match}, 32'h0);

        // counter saturation
        start = 1'b1; tick(); idle_inputs();
        m = 32'hFFFFFFFF;
        for (int i = 0; i < 260; i++) begin
            y_valid = 1'b1; y = vec(i + 100);
            m = model_step(m, vec(i + 100));
            prev = sig_out;
            tick();
            if (i == 254) chk("sat255_ovf", {23'h0, sample_cnt, cnt_ovf}, {23'h0, 8'hFF, 1'b0});
            if (i == 255) chk("sat256_ovf", {23'h0, sample_cnt, cnt_ovf}, {23'h0, 8'hFF, 1'b1});
        end
        idle_inputs();
        tests++;
        assert (sig_out !== prev) else begin
            fails++;
            $error("FAIL sat_sig_moves observed=%h expected=not %h", sig_out, prev);
        end
        chk("sat_sig", sig_out, m);
        chk("sat_cnt", {23'h0, sample_cnt, cnt_ovf}, {23'h0, 8'hFF, 1'b1});

        // start wins over finish and y_valid in RUN
        start = 1'b1; y_valid = 1'b1; y = vec(9); finish = 1'b1; golden = 32'hFFFFFFFF; tick(); idle_inputs();
        chk("prio_sig", sig_out, 32'hFFFFFFFF);
        chk("prio_cnt", {23'h0, sample_cnt, cnt_ovf}, 32'h0);
        chk("prio_flags", {30'h0, busy, done}, 32'h2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
